// File: rtl/pavana_xbar_pkg.sv
// rtl/pavana_xbar_pkg.sv - shared types and constants for the pavana crossbar end-points
package pavana_xbar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  localparam int   DATA_W    = 32;
  localparam int   ADDR_W    = 32;
  localparam int   TID_W     = 2;
  // Word index carried at full width; each responder keeps only its low ADDR_BITS.
  localparam int   IDX_W     = ADDR_W - 2;

  typedef struct packed {
    logic              cmd;
    logic [IDX_W-1:0]  idx;
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] wdata;
  } req_entry_t;

  typedef enum logic [1:0] {
    HEAD_EMPTY,
    HEAD_WAIT,
    HEAD_EXEC
  } head_state_e;

endpackage

// File: rtl/pavana_sync_fifo.sv
// rtl/pavana_sync_fifo.sv - circular-buffer FIFO with async reset of pointers and occupancy
module pavana_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wptr_d  = wptr_q + PTR_W'(push_i);
    rptr_d  = rptr_q + PTR_W'(pop_i);
    count_d = count_q + (PTR_W + 1)'(push_i) - (PTR_W + 1)'(pop_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) buf_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = buf_q[rptr_q];
  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/pavana_ooo_slave_responder.sv
// rtl/pavana_ooo_slave_responder.sv - memory-backed slave responder with in-order queue and fixed latency
module pavana_ooo_slave_responder
  import pavana_xbar_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              slave_req,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [TID_W-1:0]  slave_reqtid,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [TID_W-1:0]  slave_resptid,
  output logic [DATA_W-1:0] slave_rdata,
  output logic              slave_resp
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WCNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_RELOAD = WCNT_W'(LATENCY);

  req_entry_t        push_entry;
  req_entry_t        head_entry;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  head_state_e       head_state;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TID_W-1:0]  resptid_q, resptid_d;
  logic              mem_we;
  logic [ADDR_BITS-1:0] head_idx;
  logic [DATA_W-1:0] mem_q [2**ADDR_BITS];
  logic              unused_bits;

  // No bypass when full: a same-cycle pop does not open a slot.
  assign slave_ack = slave_req & (fifo_count != CNT_W'(DEPTH));
  assign push      = slave_ack;

  always_comb begin
    push_entry       = '0;
    push_entry.cmd   = slave_cmd;
    push_entry.idx   = slave_addr[ADDR_W-1:2];
    push_entry.tid   = slave_reqtid;
    push_entry.wdata = slave_wdata;
  end

  pavana_sync_fifo #(
    .WIDTH ($bits(req_entry_t)),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_idx    = head_entry.idx[ADDR_BITS-1:0];
  assign unused_bits = ^{head_entry.idx[IDX_W-1:ADDR_BITS], slave_addr[1:0], fifo_full};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q    <= WCNT_RELOAD;
      resp_q    <= 1'b0;
      rdata_q   <= '0;
      resptid_q <= '0;
    end else begin
      wcnt_q    <= wcnt_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      resptid_q <= resptid_d;
    end
  end

  always_comb begin
    head_state = HEAD_EMPTY;
    wcnt_d     = WCNT_RELOAD;
    if (!fifo_empty) begin
      if (wcnt_q != '0) begin
        head_state = HEAD_WAIT;
        wcnt_d     = wcnt_q - WCNT_W'(1);
      end else begin
        head_state = HEAD_EXEC;
      end
    end
  end

  always_comb begin
    pop       = 1'b0;
    mem_we    = 1'b0;
    resp_d    = 1'b0;
    rdata_d   = rdata_q;
    resptid_d = resptid_q;
    if (head_state == HEAD_EXEC) begin
      pop = 1'b1;
      if (head_entry.cmd == CMD_WRITE) begin
        mem_we = 1'b1;
      end else begin
        resp_d    = 1'b1;
        rdata_d   = mem_q[head_idx];
        resptid_d = head_entry.tid;
      end
    end
  end

  // Backing store is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[head_idx] <= head_entry.wdata;
  end

  assign slave_resp    = resp_q;
  assign slave_rdata   = rdata_q;
  assign slave_resptid = resptid_q;

endmodule

// File: tb/tb_pavana_ooo_slave_responder.sv
// tb/tb_pavana_ooo_slave_responder.sv - directed self-checking bench for the slave responder
module tb_pavana_ooo_slave_responder;
  import pavana_xbar_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic [31:0] addr, wdata;
  logic        cmd;
  logic [1:0]  tid;
  logic        ack_a, ack_b, resp_a, resp_b;
  logic [1:0]  resptid_a, resptid_b;
  logic [31:0] rdata_a, rdata_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          a_cyc[$];
  logic [1:0]  a_tid[$];
  logic [31:0] a_dat[$];
  int          b_cyc[$];
  logic [1:0]  b_tid[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pavana_ooo_slave_responder #(.DEPTH(4), .LATENCY(2), .ADDR_BITS(6)) dut_a (
    .clk_i(clk), .rst_i(rst), .slave_req(req_a), .slave_addr(addr), .slave_cmd(cmd),
    .slave_reqtid(tid), .slave_wdata(wdata), .slave_ack(ack_a), .slave_resptid(resptid_a),
    .slave_rdata(rdata_a), .slave_resp(resp_a));

  pavana_ooo_slave_responder #(.DEPTH(4), .LATENCY(0), .ADDR_BITS(6)) dut_b (
    .clk_i(clk), .rst_i(rst), .slave_req(req_b), .slave_addr(addr), .slave_cmd(cmd),
    .slave_reqtid(tid), .slave_wdata(wdata), .slave_ack(ack_b), .slave_resptid(resptid_b),
    .slave_rdata(rdata_b), .slave_resp(resp_b));

  always @(negedge clk) begin
    if (!rst && resp_a) begin
      a_cyc.push_back(cyc); a_tid.push_back(resptid_a); a_dat.push_back(rdata_a);
    end
    if (!rst && resp_b) begin
      b_cyc.push_back(cyc); b_tid.push_back(resptid_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    a_cyc.delete(); a_tid.delete(); a_dat.delete();
    b_cyc.delete(); b_tid.delete();
  endtask

  task automatic send(input bit to_b, input logic c, input logic [31:0] a, input logic [1:0] t,
                      input logic [31:0] d, input string tag, output int acc_cyc);
    cmd = c; addr = a; tid = t; wdata = d;
    if (to_b) req_b = 1'b1; else req_a = 1'b1;
    @(negedge clk);
    check(tag, to_b ? ack_b : ack_a, 1);
    acc_cyc = cyc;
    step(1);
    req_a = 1'b0; req_b = 1'b0;
  endtask

  logic exp_ack[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int t0, t1, acc, start;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    addr = '0; wdata = '0; cmd = CMD_READ; tid = '0;
    step(3);
    rst = 1'b0;

    // Reset state
    check("rst_resp", resp_a, 0);
    check("rst_rdata", rdata_a, 0);
    check("rst_resptid", resptid_a, 0);
    check("rst_ack_idle", ack_a, 0);
    req_a = 1'b1; #1;
    check("rst_ack_req", ack_a, 1);
    req_a = 1'b0;
    step(1);

    // Write/read round trip
    clear_logs();
    send(0, CMD_WRITE, 32'h10, 2'd1, 32'hDEADBEEF, "rt_wr_ack", t0);
    send(0, CMD_READ,  32'h10, 2'd2, 32'h0,        "rt_rd_ack", t1);
    step(12);
    check("rt_nresp", a_cyc.size(), 1);
    if (a_cyc.size() == 1) begin
      check("rt_cycle", a_cyc[0], t0 + 7);
      check("rt_tid", a_tid[0], 2);
      check("rt_data", a_dat[0], 32'hDEADBEEF);
    end

    // Single read latency into an empty queue
    clear_logs();
    send(0, CMD_READ, 32'h10, 2'd3, 32'h0, "lat_ack", t0);
    step(10);
    check("lat_nresp", a_cyc.size(), 1);
    if (a_cyc.size() == 1) begin
      check("lat_cycle", a_cyc[0], t0 + 4);
      check("lat_tid", a_tid[0], 3);
    end

    // Full queue with req held high
    clear_logs();
    acc = 0; start = 0;
    cmd = CMD_READ; addr = 32'h10; req_a = 1'b1;
    for (int i = 0; i < 30 && acc < 8; i++) begin
      tid = acc[1:0];
      @(negedge clk);
      if (i == 0) start = cyc;
      if (i < 14) check($sformatf("full_ack_c%0d", i), ack_a, exp_ack[i]);
      if (ack_a) acc++;
      step(1);
    end
    req_a = 1'b0;
    check("full_accepted", acc, 8);
    step(20);
    check("full_nresp", a_cyc.size(), 8);
    if (a_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("full_cycle_%0d", i), a_cyc[i], start + 4 + 3 * i);
        check($sformatf("full_tid_%0d", i), a_tid[i], i % 4);
      end
    end

    // Reset mid-operation
    clear_logs();
    cmd = CMD_READ; addr = 32'h10; req_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tid = 2'(i + 1);
      @(negedge clk);
      if (i == 0) t0 = cyc;
      step(1);
    end
    req_a = 1'b0;
    step(1);
    @(negedge clk);
    check("mid_resp_before", resp_a, 1);
    check("mid_resp_cycle", cyc, t0 + 4);
    #2 rst = 1'b1;
    #1;
    check("mid_resp_async", resp_a, 0);
    step(1);
    rst = 1'b0;
    clear_logs();
    req_a = 1'b1; #1;
    check("mid_ack_after", ack_a, 1);
    req_a = 1'b0;
    step(20);
    check("mid_nresp", a_cyc.size(), 0);

    // Address aliasing above ADDR_BITS
    clear_logs();
    send(0, CMD_WRITE, 32'h104, 2'd0, 32'hA5A5A5A5, "alias_wr_ack", t0);
    step(6);
    send(0, CMD_READ, 32'h004, 2'd1, 32'h0, "alias_rd_ack", t1);
    step(8);
    check("alias_nresp", a_cyc.size(), 1);
    if (a_cyc.size() == 1) check("alias_data", a_dat[0], 32'hA5A5A5A5);

    // Zero-latency streaming
    clear_logs();
    cmd = CMD_READ; addr = 32'h20; req_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tid = 2'(i);
      @(negedge clk);
      if (i == 0) t0 = cyc;
      check($sformatf("stream_ack_%0d", i), ack_b, 1);
      step(1);
    end
    req_b = 1'b0;
    step(6);
    check("stream_nresp", b_cyc.size(), 16);
    if (b_cyc.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("stream_cycle_%0d", i), b_cyc[i], t0 + 2 + i);
        check($sformatf("stream_tid_%0d", i), b_tid[i], i % 4);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
